fun_down_counter: RTL and testbench
===================================

Name: fun_down_counter

Overview:
Loadable, WIDTH-bit countdown counter/timer. It is the decrementing counterpart of the lab up-counter. Software or an upstream FSM loads a count, issues START, and the block decrements on each DEC strobe until it reaches zero, then reports DONE. It sits beside the up-counter in the lab datapath as a reusable event timer, with optional auto-reload for periodic ticks.

Parameters:
WIDTH, 4, counter width in bits (2..16)
AUTO_RELOAD, 0, 1 = reload the last loaded value on terminal count and keep running; 0 = stop at zero

Ports:
CLK  input  1  system clock; all state changes on its rising edge
RST_N  input  1  asynchronous, active-low reset
CLR  input  1  synchronous clear: Q to 0, FSM to IDLE
LOAD  input  1  synchronous load of LD_VAL into Q and the reload register
LD_VAL  input  WIDTH  value captured on LOAD
START  input  1  begin countdown (acted on only in IDLE)
DEC  input  1  decrement strobe; acted on only in RUN
Q  output  WIDTH  registered count
NXT  output  WIDTH  combinational next value of Q (the D input of the Q register)
BUSY  output  1  high while FSM is in RUN
ZERO  output  1  combinational, Q == 0
DONE  output  1  registered one-cycle terminal-count pulse

Behaviour:
- Reset (RST_N low, asynchronous): Q=0, reload register=0, FSM=IDLE, DONE=0, BUSY=0. Outputs hold these values until the first rising CLK edge after RST_N deasserts.
- FSM states: IDLE, RUN, DONE. BUSY is high only in RUN.
- Input priority each cycle: CLR > LOAD > START > DEC.
- CLR, from any state: Q<=0, FSM<=IDLE, DONE<=0. The reload register is unchanged.
- LOAD, from any state: Q<=LD_VAL, reload<=LD_VAL, FSM<=IDLE, DONE<=0. LOAD aborts a run in progress.
- IDLE + START:
  - Q!=0: FSM<=RUN.
  - Q==0: FSM<=DONE, DONE<=1 on the next edge. A zero-length timer completes in 1 cycle.
- IDLE or DONE + DEC: ignored; Q holds.
- RUN + DEC with Q>1: Q<=Q-1.
- RUN + DEC with Q==1:
  - AUTO_RELOAD=0: Q<=0, FSM<=DONE, DONE<=1.
  - AUTO_RELOAD=1: Q<=reload, FSM stays RUN, DONE<=1.
- RUN without DEC: Q holds. START in RUN is ignored.
- DONE state lasts exactly one cycle and then goes to IDLE. START while in DONE is ignored.
- DONE output is high for exactly the one cycle following the decrement to terminal count. It is cleared the following cycle unless another terminal count occurs. With AUTO_RELOAD=1 and reload==1, DONE stays high on consecutive cycles while DEC is held.
- Arithmetic: Q never decrements below 0 and never wraps, because the FSM leaves RUN at 1→0. Q-1 is computed modulo 2^WIDTH, but the 0-1 case is unreachable.
- NXT always equals the value Q takes at the next edge, given the current inputs and state (RST_N aside).
- RST_N asserted mid-run: immediate return to reset values. No DONE pulse is generated.

Test Plan:
- Reset/load: assert RST_N=0 mid-run with Q=7 → Q=0, BUSY=0, DONE=0 immediately (no clock). Release, then LOAD LD_VAL=5 → Q=5, IDLE.
- Basic countdown: LOAD 3, START, DEC held high → Q reads 3,2,1,0 on successive edges. DONE=1 for exactly 1 cycle after Q=0. BUSY drops with DONE. Further DEC leaves Q=0.
- Gapped DEC: LOAD 4, START, DEC toggled 1,0,1,0 → Q decrements only on DEC=1 cycles. NXT==Q on DEC=0 cycles.
- Zero start: CLR, then START → no RUN state. DONE=1 one cycle later, ZERO=1 throughout.
- Priority/abort: in RUN at Q=2, assert LOAD=1 (LD_VAL=9), DEC=1 and CLR=1 together → Q=0, IDLE. Repeat with CLR=0 → Q=9, IDLE, no DONE.
- AUTO_RELOAD=1, WIDTH=4: LOAD 2, START, DEC held for 6 cycles → Q reads 2,1,2,1,2,1. DONE pulses on the cycles after each 1→reload transition. BUSY stays 1.

Source files
------------

// File: rtl/fun_down_counter.sv
// Loadable WIDTH-bit countdown timer with IDLE/RUN/DONE control, a one-cycle
// terminal-count pulse and optional auto-reload of the last loaded value.
module fun_down_counter #(
  parameter int WIDTH       = 4,
  parameter int AUTO_RELOAD = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LD_VAL,
  input  logic             START,
  input  logic             DEC,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] NXT,
  output logic             BUSY,
  output logic             ZERO,
  output logic             DONE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      q_q      <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (CLR) begin
      q_d     = '0;
      state_d = S_IDLE;
    end else if (LOAD) begin
      q_d      = LD_VAL;
      reload_d = LD_VAL;
      state_d  = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            if (q_q == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          // Terminal count is detected at 1 so Q never has to wrap below zero.
          if (DEC) begin
            if (q_q == ONE) begin
              done_d = 1'b1;
              if (AUTO_RELOAD != 0) begin
                q_d = reload_q;
              end else begin
                q_d     = '0;
                state_d = S_DONE;
              end
            end else if (q_q != '0) begin
              q_d = q_q - ONE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign Q    = q_q;
  assign NXT  = q_d;
  assign BUSY = (state_q == S_RUN);
  assign ZERO = (q_q == '0);
  assign DONE = done_q;

endmodule

// File: tb/tb_fun_down_counter.sv
// Directed bench for fun_down_counter: a stop-at-zero and an auto-reload
// instance share stimulus and are checked every cycle against a timer model.
module tb_fun_down_counter;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       CLR = 1'b0, LOAD = 1'b0, START = 1'b0, DEC = 1'b0;
  logic [3:0] LD_VAL = 4'd0;

  logic [3:0] q0, nxt0, q1, nxt1;
  logic       busy0, zero0, done0, busy1, zero1, done1;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  fun_down_counter #(.WIDTH(4), .AUTO_RELOAD(0)) u_stop (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .LOAD(LOAD), .LD_VAL(LD_VAL),
    .START(START), .DEC(DEC), .Q(q0), .NXT(nxt0), .BUSY(busy0),
    .ZERO(zero0), .DONE(done0)
  );

  fun_down_counter #(.WIDTH(4), .AUTO_RELOAD(1)) u_auto (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .LOAD(LOAD), .LD_VAL(LD_VAL),
    .START(START), .DEC(DEC), .Q(q1), .NXT(nxt1), .BUSY(busy1),
    .ZERO(zero1), .DONE(done1)
  );

  // Timer model: a count, the remembered load value, whether it is timing,
  // whether it is in its single post-expiry cycle, and the expiry pulse.
  typedef struct {
    int count;
    int reload;
    bit timing;
    bit expired;
    bit pulse;
  } timer_t;

  timer_t m_stop, m_auto;

  function automatic timer_t timer_step(timer_t t, bit periodic);
    timer_t n;
    n         = t;
    n.pulse   = 1'b0;
    n.expired = 1'b0;
    if (CLR) begin
      n.count  = 0;
      n.timing = 1'b0;
    end else if (LOAD) begin
      n.count  = int'(LD_VAL);
      n.reload = int'(LD_VAL);
      n.timing = 1'b0;
    end else if (!t.timing && !t.expired && START) begin
      if (t.count == 0) begin
        n.expired = 1'b1;
        n.pulse   = 1'b1;
      end else begin
        n.timing = 1'b1;
      end
    end else if (t.timing && DEC && t.count > 0) begin
      n.count = t.count - 1;
      if (n.count == 0) begin
        n.pulse = 1'b1;
        if (periodic) n.count = t.reload;
        else begin
          n.timing  = 1'b0;
          n.expired = 1'b1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_stop = '{0, 0, 1'b0, 1'b0, 1'b0};
      m_auto = '{0, 0, 1'b0, 1'b0, 1'b0};
    end else begin
      m_stop = timer_step(m_stop, 1'b0);
      m_auto = timer_step(m_auto, 1'b1);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison on the falling edge, away from input changes.
  always @(negedge CLK) begin
    timer_t ns, na;
    ns = timer_step(m_stop, 1'b0);
    na = timer_step(m_auto, 1'b1);
    chk("stop.Q",    int'(q0),    m_stop.count);
    chk("stop.NXT",  int'(nxt0),  RST_N ? ns.count : 0);
    chk("stop.BUSY", int'(busy0), int'(m_stop.timing));
    chk("stop.ZERO", int'(zero0), int'(m_stop.count == 0));
    chk("stop.DONE", int'(done0), int'(m_stop.pulse));
    chk("auto.Q",    int'(q1),    m_auto.count);
    chk("auto.NXT",  int'(nxt1),  RST_N ? na.count : 0);
    chk("auto.BUSY", int'(busy1), int'(m_auto.timing));
    chk("auto.ZERO", int'(zero1), int'(m_auto.count == 0));
    chk("auto.DONE", int'(done1), int'(m_auto.pulse));
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit clr, input bit load, input int val,
                       input bit start, input bit dec);
    CLR = clr; LOAD = load; LD_VAL = 4'(val); START = start; DEC = dec;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("reset.Q", int'(q0), 0);
    chk("reset.BUSY", int'(busy0), 0);
    chk("reset.DONE", int'(done0), 0);
    cyc(); cyc();
    RST_N = 1'b1;
    cyc();

    // Async reset mid-run with Q=7, then load 5.
    drive(0, 1, 7, 0, 0); cyc();
    drive(0, 0, 0, 1, 0); cyc();
    chk("run7.Q", int'(q0), 7);
    chk("run7.BUSY", int'(busy0), 1);
    drive(0, 0, 0, 0, 0);
    RST_N = 1'b0;
    #1;
    chk("arst.Q", int'(q0), 0);
    chk("arst.BUSY", int'(busy0), 0);
    chk("arst.DONE", int'(done0), 0);
    cyc();
    RST_N = 1'b1;
    cyc();
    drive(0, 1, 5, 0, 0); cyc();
    drive(0, 0, 0, 0, 0);
    chk("load5.Q", int'(q0), 5);
    chk("load5.BUSY", int'(busy0), 0);
    cyc();

    // Basic countdown from 3 with DEC held.
    drive(0, 1, 3, 0, 0); cyc();
    drive(0, 0, 0, 1, 0); cyc();
    chk("cd.Q3", int'(q0), 3);
    drive(0, 0, 0, 0, 1); cyc();
    chk("cd.Q2", int'(q0), 2);
    cyc();
    chk("cd.Q1", int'(q0), 1);
    chk("cd.DONE_early", int'(done0), 0);
    cyc();
    chk("cd.Q0", int'(q0), 0);
    chk("cd.DONE", int'(done0), 1);
    chk("cd.BUSY", int'(busy0), 0);
    cyc();
    chk("cd.DONE_off", int'(done0), 0);
    chk("cd.hold0", int'(q0), 0);
    cyc();
    chk("cd.stay0", int'(q0), 0);

    // Gapped DEC from 4.
    drive(0, 1, 4, 0, 0); cyc();
    drive(0, 0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0, 1); cyc();
    chk("gap.Q3", int'(q0), 3);
    drive(0, 0, 0, 0, 0); #1;
    chk("gap.NXT_hold", int'(nxt0), 3);
    cyc();
    chk("gap.Q3b", int'(q0), 3);
    drive(0, 0, 0, 0, 1); cyc();
    chk("gap.Q2", int'(q0), 2);
    drive(0, 0, 0, 0, 0); cyc();
    chk("gap.Q2b", int'(q0), 2);

    // Zero-length timer.
    drive(1, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 1, 0); cyc();
    chk("zs.DONE", int'(done0), 1);
    chk("zs.BUSY", int'(busy0), 0);
    chk("zs.ZERO", int'(zero0), 1);
    drive(0, 0, 0, 0, 0); cyc();
    chk("zs.DONE_off", int'(done0), 0);

    // Priority: CLR beats LOAD/DEC, then LOAD aborts a run.
    drive(0, 1, 3, 0, 0); cyc();
    drive(0, 0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0, 1); cyc();
    chk("pri.Q2", int'(q0), 2);
    drive(1, 1, 9, 0, 1); cyc();
    chk("pri.clr_Q", int'(q0), 0);
    chk("pri.clr_BUSY", int'(busy0), 0);
    drive(0, 1, 3, 0, 0); cyc();
    drive(0, 0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0, 1); cyc();
    drive(0, 1, 9, 0, 1); cyc();
    chk("pri.load_Q", int'(q0), 9);
    chk("pri.load_BUSY", int'(busy0), 0);
    chk("pri.load_DONE", int'(done0), 0);

    // Auto-reload instance: load 2, DEC held.
    drive(0, 1, 2, 0, 0); cyc();
    drive(0, 0, 0, 1, 0); cyc();
    chk("ar.Q2", int'(q1), 2);
    drive(0, 0, 0, 0, 1); cyc();
    chk("ar.Q1", int'(q1), 1);
    chk("ar.DONE0", int'(done1), 0);
    cyc();
    chk("ar.Q2b", int'(q1), 2);
    chk("ar.DONE1", int'(done1), 1);
    chk("ar.BUSY", int'(busy1), 1);
    cyc();
    chk("ar.Q1b", int'(q1), 1);
    chk("ar.DONE_off", int'(done1), 0);
    cyc();
    chk("ar.Q2c", int'(q1), 2);
    chk("ar.DONE2", int'(done1), 1);
    cyc();
    chk("ar.Q1c", int'(q1), 1);
    chk("ar.BUSYc", int'(busy1), 1);

    // Auto-reload with reload==1: DONE held while DEC held.
    drive(0, 1, 1, 0, 0); cyc();
    drive(0, 0, 0, 1, 0); cyc();
    drive(0, 0, 0, 0, 1); cyc();
    chk("ar1.DONE_a", int'(done1), 1);
    cyc();
    chk("ar1.DONE_b", int'(done1), 1);
    chk("ar1.Q", int'(q1), 1);
    drive(0, 0, 0, 0, 0); cyc();
    chk("ar1.DONE_off", int'(done1), 0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
